// File: rtl/avalon_bus_master.sv
// Avalon-MM load/store master: queues commands, steers byte lanes, sign/zero-extends loads.
// Latency: push-to-response 3 cycles with no wait states (+1 per waitrequest cycle), 2 for rejected commands.
// Backpressure: cmd_ready low while the command FIFO is full; bus outputs held stable while waitrequest is high.

// Generic command FIFO with registered pointers; one extra pointer bit tells full from empty.
// Latency: an entry pushed at an edge is visible at the head in the following cycle.
// Backpressure: push_rdy is simply !full; a same-cycle pop does not reopen it.
module abm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, empty, do_push, do_pop;

  // Occupancy flags and pointer advance; pointers wrap naturally modulo 2*DEPTH.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
               (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    push_rdy = !full;
    pop_vld  = !empty;
    do_push  = push_vld && !full;
    do_pop   = pop_rdy && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    pop_dat  = mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers guard them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_dat;
  end
endmodule

module avalon_bus_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [1:0]          cmd_size,
  input  logic                cmd_signed,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   address,
  output logic                write,
  output logic                read,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);
  localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              sgn;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t push_dat, head;
  logic head_vld, pop;

  logic [1:0]        state_q, state_d, size_q, size_d;
  logic              write_q, write_d, sgn_q, sgn_d, err_q, err_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BYTES-1:0]  be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

  logic [OFS_W-1:0]  head_ofs;
  logic              head_legal, head_aligned;
  logic [BYTES-1:0]  head_be;
  logic [DATA_W-1:0] shifted, ext;
  logic              fill;
  int                nbits;

  assign push_dat = '{write: cmd_write, addr: cmd_addr, size: cmd_size, sgn: cmd_signed, wdata: cmd_wdata};

  abm_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push_vld (cmd_valid),
    .push_rdy (cmd_ready),
    .push_dat (push_dat),
    .pop_vld  (head_vld),
    .pop_rdy  (pop),
    .pop_dat  (head)
  );

  // Decode the head command: legality, natural alignment and the lane mask.
  always_comb begin
    head_ofs     = head.addr[OFS_W-1:0];
    head_legal   = (int'(head.size) <= OFS_W);
    head_aligned = 1'b1;
    for (int i = 0; i < OFS_W; i++)
      if (i < int'(head.size) && head_ofs[i]) head_aligned = 1'b0;
    head_be = '0;
    for (int i = 0; i < BYTES; i++)
      if (i >= int'(head_ofs) && i < int'(head_ofs) + (1 << head.size)) head_be[i] = 1'b1;
  end

  // Right-justify the returned lanes and extend; a full-width access has nothing to extend.
  always_comb begin
    shifted = readdata >> {ofs_q, 3'b000};
    nbits   = 8 << size_q;
    if (nbits > DATA_W) nbits = DATA_W;
    fill = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (i == nbits - 1) fill = sgn_q & shifted[i];
    for (int i = 0; i < DATA_W; i++)
      ext[i] = (i < nbits) ? shifted[i] : fill;
  end

  // Control FSM: pop into holding registers, run one bus cycle, then pulse the response.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    err_d   = err_q;
    ofs_d   = ofs_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_vld) begin
          pop     = 1'b1;
          write_d = head.write;
          size_d  = head.size;
          sgn_d   = head.sgn;
          ofs_d   = head_ofs;
          addr_d  = {head.addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
          rdata_d = '0;
          if (head_legal && head_aligned) begin
            err_d   = 1'b0;
            be_d    = head_be;
            wdata_d = head.wdata << {head_ofs, 3'b000};
            state_d = BUS;
          end else begin
            err_d   = 1'b1;
            be_d    = '0;
            wdata_d = '0;
            state_d = RESP;
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          if (!write_q) rdata_d = ext;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and holding registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      ofs_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
      ofs_q   <= ofs_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode straight from registered state, so reset clears strobes at once.
  always_comb begin
    read       = (state_q == BUS) && !write_q;
    write      = (state_q == BUS) && write_q;
    address    = addr_q;
    byteenable = be_q;
    writedata  = wdata_q;
    rsp_valid  = (state_q == RESP);
    rsp_err    = rsp_valid && err_q;
    rsp_rdata  = rdata_q;
    busy       = head_vld || (state_q != IDLE);
  end
endmodule
